kernel_b_vout_sink: RTL and testbench

Downstream stage for the `kb_vout` leaf map node. It captures the node's registered `out1` stream into a small synchronous FIFO. It drives the shared pipeline `stall` from FIFO occupancy and presents results on a valid/ready stream to the host/memory writer. It also counts elements per work-group and flags the last one, so the writer can close each burst.

---
 rtl/kernel_b_vout_sink.sv | 107 ++++++++++
 tb/tb_kernel_b_vout_sink.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_b_vout_sink.sv
// kernel_b_vout_sink: captures the kb_vout node's out1 stream into a small FIFO,
// throttles the pipeline through stall, and presents results on a valid/ready
// stream with a per-work-group last flag.
module kernel_b_vout_sink #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SLACK = 2,
  parameter int unsigned NELEM = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATAW-1:0]         in_data,
  output logic                     stall,
  output logic                     out_valid,
  output logic [DATAW-1:0]         out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned EW  = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int unsigned THR = DEPTH - SLACK;

  localparam logic [EW-1:0] LAST_IDX = EW'(NELEM - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] THR_CNT  = CW'(THR);

  logic [DATAW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [EW-1:0]    r_ecnt;
  logic             r_valid;
  logic             r_stall;
  logic             r_last;
  logic             r_overflow;

  logic             w_stall;
  logic             w_full;
  logic             w_wr_req;
  logic             w_wr;
  logic             w_rd;
  logic [CW-1:0]    w_count_nxt;
  logic [EW-1:0]    w_ecnt_nxt;

  // stall comes straight from its register; kept as a separate net so it has one source
  assign w_stall = r_stall;

  // Handshake decode and next occupancy / element index
  always_comb begin
    w_full      = (r_count == FULL_CNT);
    w_wr_req    = in_valid & ~w_stall;
    w_wr        = w_wr_req & ~w_full;
    w_rd        = r_valid & out_ready;
    w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);
    w_ecnt_nxt  = r_ecnt;
    if (w_rd) begin
      w_ecnt_nxt = (r_ecnt == LAST_IDX) ? '0 : r_ecnt + EW'(1);
    end
  end

  // Pointers, occupancy, element counter and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ecnt     <= '0;
      r_valid    <= 1'b0;
      r_stall    <= 1'b0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= w_count_nxt;
      r_ecnt     <= w_ecnt_nxt;
      r_valid    <= (w_count_nxt != '0);
      r_stall    <= (w_count_nxt >= THR_CNT);
      r_last     <= (w_count_nxt != '0) && (w_ecnt_nxt == LAST_IDX);
      r_overflow <= r_overflow | (w_wr_req & w_full);
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign stall     = w_stall;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign out_data  = r_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_kernel_b_vout_sink.sv
// Bench for kernel_b_vout_sink (DEPTH=8, SLACK=2, NELEM=4) with a queue scoreboard.
module tb_kernel_b_vout_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic [3:0]  count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic        obs_last[$];
  int          m_count = 0;
  int          m_ecnt  = 0;
  bit          m_force = 1'b0;

  kernel_b_vout_sink #(.DATAW(32), .DEPTH(8), .SLACK(2), .NELEM(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // advance the model by one cycle using the current inputs, then step past the edge
  task automatic advance(output bit acc);
    bit en, wr, rd;
    en = m_force ? 1'b1 : (m_count < 6);
    wr = in_valid && en && (m_count < 8);
    rd = (m_count != 0) && out_ready;
    if (rd) begin
      void'(exp_q.pop_front());
      m_ecnt = (m_ecnt == 3) ? 0 : m_ecnt + 1;
    end
    if (wr) exp_q.push_back(in_data);
    m_count = m_count + int'(wr) - int'(rd);
    acc = wr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_count = 0; m_ecnt = 0;
  endtask

  // stream n elements with out_ready high, recording the last flag of each popped element
  task automatic stream_n(input int n);
    int s = 0;
    int cyc = 0;
    bit acc;
    while ((s < n || exp_q.size() != 0) && cyc < 200) begin
      in_valid = (s < n); in_data = 32'(500 + s); out_ready = 1'b1;
      if (out_valid) obs_last.push_back(out_last);
      advance(acc);
      if (acc) s++;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_vec++; if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", out_last); end
  endtask

  task automatic test_streaming();
    bit acc;
    for (int i = 1; i <= 18; i++) begin
      in_valid = (i <= 16); in_data = 32'(i); out_ready = 1'b1;
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL stream_stall: got %b want 0", stall); end
      n_vec++; if (count !== 4'(m_count) || count > 4'd1) begin n_err++; $display("FAIL stream_count: got %0d want %0d", count, m_count); end
      n_vec++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL stream_valid: got %b want %b", out_valid, exp_q.size() != 0); end
      if (i >= 2 && i <= 17) begin
        n_vec++; if (out_data !== 32'(i - 1)) begin n_err++; $display("FAIL stream_data: got %0d want %0d", out_data, i - 1); end
        n_vec++; if (out_last !== (m_ecnt == 3)) begin n_err++; $display("FAIL stream_last: got %b want %b", out_last, m_ecnt == 3); end
      end
      advance(acc);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'(100 + i); out_ready = 1'b0;
      n_vec++; if (count !== 4'(m_count)) begin n_err++; $display("FAIL bp_count: got %0d want %0d", count, m_count); end
      n_vec++; if (stall !== (m_count >= 6)) begin n_err++; $display("FAIL bp_stall: got %b want %b", stall, m_count >= 6); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_overflow: got %b want 0", overflow); end
      advance(acc);
    end
    n_vec++; if (count !== 4'd6) begin n_err++; $display("FAIL bp_full_count: got %0d want 6", count); end
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL bp_full_stall: got %b want 1", stall); end
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_ready = 1'b1;
      if (i < 6) begin
        n_vec++; if (out_valid !== 1'b1 || out_data !== 32'(100 + i)) begin n_err++; $display("FAIL bp_drain_data: got %b/%0d want 1/%0d", out_valid, out_data, 100 + i); end
      end
      n_vec++; if (stall !== (m_count >= 6)) begin n_err++; $display("FAIL bp_drain_stall: got %b want %b (count %0d)", stall, m_count >= 6, m_count); end
      advance(acc);
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    bit acc;
    int sent = 0;
    int cyc = 0;
    logic [31:0] pend;
    logic        hold = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;
    do_reset();
    pend = $urandom;
    while ((sent < 200 || exp_q.size() != 0) && cyc < 3000) begin
      in_valid = (sent < 200); in_data = pend; out_ready = 1'($urandom_range(0, 1));
      n_vec++; if (count !== 4'(m_count)) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", count, m_count); end
      n_vec++; if (out_valid !== (m_count != 0)) begin n_err++; $display("FAIL rnd_valid: got %b want %b", out_valid, m_count != 0); end
      if (exp_q.size() != 0) begin
        n_vec++; if (out_data !== exp_q[0]) begin n_err++; $display("FAIL rnd_data: got %h want %h", out_data, exp_q[0]); end
        n_vec++; if (out_last !== (m_ecnt == 3)) begin n_err++; $display("FAIL rnd_last: got %b want %b", out_last, m_ecnt == 3); end
      end
      if (hold) begin
        n_vec++; if (out_data !== hold_data || out_last !== hold_last) begin n_err++; $display("FAIL rnd_stable: got %h/%b want %h/%b", out_data, out_last, hold_data, hold_last); end
      end
      hold = out_valid && !out_ready; hold_data = out_data; hold_last = out_last;
      advance(acc);
      if (acc) begin sent++; pend = $urandom; end
      cyc++;
    end
    in_valid = 1'b0;
    n_vec++; if (cyc >= 3000) begin n_err++; $display("FAIL rnd_timeout: got %0d cycles want < 3000", cyc); end
  endtask

  task automatic test_last();
    do_reset();
    obs_last.delete();
    stream_n(12);
    n_vec++; if (obs_last.size() != 12) begin n_err++; $display("FAIL last_cnt: got %0d want 12", obs_last.size()); end
    for (int k = 0; k < obs_last.size(); k++) begin
      n_vec++; if (obs_last[k] !== (k == 3 || k == 7 || k == 11)) begin n_err++; $display("FAIL last_flag[%0d]: got %b want %b", k, obs_last[k], k % 4 == 3); end
    end
    obs_last.delete();
    stream_n(6);
    do_reset();
    obs_last.delete();
    stream_n(4);
    n_vec++; if (obs_last.size() != 4) begin n_err++; $display("FAIL last_rst_cnt: got %0d want 4", obs_last.size()); end
    for (int k = 0; k < obs_last.size(); k++) begin
      n_vec++; if (obs_last[k] !== (k == 3)) begin n_err++; $display("FAIL last_rst_flag[%0d]: got %b want %b", k, obs_last[k], k == 3); end
    end
  endtask

  task automatic test_overflow();
    bit acc;
    int s = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 32'(200 + s); out_ready = 1'b0;
      advance(acc);
      if (acc) s++;
    end
    force dut.w_stall = 1'b0;
    m_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(200 + s); out_ready = 1'b0;
      advance(acc);
      if (acc) s++;
    end
    release dut.w_stall;
    m_force = 1'b0;
    in_valid = 1'b0;
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
    for (int i = 0; i < 9; i++) begin
      out_ready = 1'b1;
      if (i < 8) begin
        n_vec++; if (out_data !== 32'(200 + i)) begin n_err++; $display("FAIL ovf_drain: got %0d want %0d", out_data, 200 + i); end
      end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_hold: got %b want 1", overflow); end
      advance(acc);
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
    do_reset();
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_last();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
